// File: rtl/async_sram_ctrl.sv
// async_sram_ctrl: single-request controller for an asynchronous SRAM with programmable read/write wait states and read-to-write turnaround.
module async_sram_ctrl #(
  parameter int ADDR_W  = 18,
  parameter int DATA_W  = 16,
  parameter int WAIT_RD = 1,
  parameter int WAIT_WR = 1,
  parameter int TURN    = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic                  cmd_we,
  input  logic [ADDR_W-1:0]     cmd_addr,
  input  logic [DATA_W-1:0]     cmd_wdata,
  input  logic [DATA_W/8-1:0]   cmd_be,
  output logic                  rsp_valid,
  output logic [DATA_W-1:0]     rsp_rdata,
  output logic [ADDR_W-1:0]     sram_a,
  output logic [DATA_W-1:0]     sram_dq_o,
  output logic                  sram_dq_oe,
  input  logic [DATA_W-1:0]     sram_dq_i,
  output logic                  sram_ce_n,
  output logic                  sram_oe_n,
  output logic                  sram_we_n,
  output logic [DATA_W/8-1:0]   sram_be_n
);
  localparam int BW = DATA_W / 8;
  typedef enum logic [2:0] {S_IDLE, S_RD, S_WR_SETUP, S_WR_PULSE, S_WR_HOLD, S_TURN} state_t;
  state_t state, nxt;
  logic [3:0] cnt, cnt_nxt;
  logic acc, wr_nxt, ce_d, oe_d, we_d;
  logic [BW-1:0] be_d;
  assign cmd_ready = state == S_IDLE;
  assign acc = cmd_valid & cmd_ready;
  always_comb begin
    nxt = state;
    cnt_nxt = cnt;
    case (state)
      S_IDLE: if (acc) begin
        nxt = cmd_we ? S_WR_SETUP : S_RD;
        cnt_nxt = 4'(WAIT_RD);
      end
      S_RD: if (cnt == 4'd0) begin
        nxt = TURN == 0 ? S_IDLE : S_TURN;
        cnt_nxt = 4'(TURN == 0 ? 0 : TURN - 1);
      end else cnt_nxt = cnt - 4'd1;
      S_WR_SETUP: begin
        nxt = S_WR_PULSE;
        cnt_nxt = 4'(WAIT_WR);
      end
      S_WR_PULSE: if (cnt == 4'd0) nxt = S_WR_HOLD;
        else cnt_nxt = cnt - 4'd1;
      S_WR_HOLD: nxt = S_IDLE;
      S_TURN: if (cnt == 4'd0) nxt = S_IDLE;
        else cnt_nxt = cnt - 4'd1;
      default: nxt = S_IDLE;
    endcase
  end
  // Strobes are decoded from the next state and registered so they change cleanly with the state.
  always_comb begin
    wr_nxt = nxt == S_WR_SETUP || nxt == S_WR_PULSE || nxt == S_WR_HOLD;
    be_d = acc ? (cmd_we ? ~cmd_be : '0) : (nxt == S_IDLE || nxt == S_TURN) ? '1 : sram_be_n;
    ce_d = !(nxt == S_RD || wr_nxt);
    oe_d = nxt != S_RD;
    we_d = !(nxt == S_WR_PULSE && |(~be_d));
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= S_IDLE;
      cnt <= '0;
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
      sram_a <= '0;
      sram_dq_o <= '0;
      sram_dq_oe <= 1'b0;
      sram_ce_n <= 1'b1;
      sram_oe_n <= 1'b1;
      sram_we_n <= 1'b1;
      sram_be_n <= '1;
    end else begin
      state <= nxt;
      cnt <= cnt_nxt;
      rsp_valid <= state == S_RD && cnt == 4'd0;
      if (state == S_RD && cnt == 4'd0) rsp_rdata <= sram_dq_i;
      if (acc) sram_a <= cmd_addr;
      if (acc) sram_dq_o <= cmd_wdata;
      sram_dq_oe <= wr_nxt;
      sram_ce_n <= ce_d;
      sram_oe_n <= oe_d;
      sram_we_n <= we_d;
      sram_be_n <= be_d;
    end
  end
endmodule

// File: tb/tb_async_sram_ctrl.sv
// tb_async_sram_ctrl: directed scoreboard bench with a behavioural SRAM for the default build and a WAIT_RD=3/TURN=0 build.
module tb_async_sram_ctrl;
  logic clk = 0, rst = 1;
  always #5 clk = ~clk;
  logic cmd_valid = 0, cmd_ready, cmd_we = 0, rsp_valid, dq_oe, ce_n, oe_n, we_n;
  logic [17:0] cmd_addr = '0, sram_a;
  logic [15:0] cmd_wdata = '0, rsp_rdata, dq_o, dq_i;
  logic [1:0] cmd_be = '0, be_n;
  logic c1_valid = 0, c1_ready, c1_we = 0, c1_rv, c1_oe, c1_ce_n, c1_oe_n, c1_we_n;
  logic [17:0] c1_addr = 18'h5, c1_a;
  logic [15:0] c1_wdata = '0, c1_rdata, c1_dq_o, c1_dq_i;
  logic [1:0] c1_be = '0, c1_be_n;
  logic [15:0] mem [0:255];
  logic [15:0] sb [$];
  logic tr_we [16], tr_oe [16], tr_rdy [16], tr_rv [16];
  int tests = 0, failed = 0;

  async_sram_ctrl dut (.clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_we(cmd_we),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_be(cmd_be), .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata),
    .sram_a(sram_a), .sram_dq_o(dq_o), .sram_dq_oe(dq_oe), .sram_dq_i(dq_i), .sram_ce_n(ce_n),
    .sram_oe_n(oe_n), .sram_we_n(we_n), .sram_be_n(be_n));
  async_sram_ctrl #(.WAIT_RD(3), .TURN(0)) dut1 (.clk(clk), .rst(rst), .cmd_valid(c1_valid), .cmd_ready(c1_ready),
    .cmd_we(c1_we), .cmd_addr(c1_addr), .cmd_wdata(c1_wdata), .cmd_be(c1_be), .rsp_valid(c1_rv), .rsp_rdata(c1_rdata),
    .sram_a(c1_a), .sram_dq_o(c1_dq_o), .sram_dq_oe(c1_oe), .sram_dq_i(c1_dq_i), .sram_ce_n(c1_ce_n),
    .sram_oe_n(c1_oe_n), .sram_we_n(c1_we_n), .sram_be_n(c1_be_n));

  assign dq_i = (!ce_n && !oe_n) ? mem[sram_a[7:0]] : 16'h0;
  assign c1_dq_i = (!c1_ce_n && !c1_oe_n) ? 16'h5A5A : 16'h0;
  always @(posedge clk) if (!ce_n && !we_n) begin
    if (!be_n[0]) mem[sram_a[7:0]][7:0] <= dq_o[7:0];
    if (!be_n[1]) mem[sram_a[7:0]][15:8] <= dq_o[15:8];
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) if (!rst) begin
    chk("oe_dq_excl", 32'(!oe_n && dq_oe), 0);
    if (rsp_valid) begin
      if (sb.size() == 0) chk("unexpected_rsp", 32'(rsp_rdata), 32'hFFFF_FFFF);
      else chk("rdata", 32'(rsp_rdata), 32'(sb.pop_front()));
    end
  end

  task automatic issue(input logic we, input logic [17:0] addr, input logic [15:0] wd, input logic [1:0] be,
                       input logic [15:0] exp, input bit hold);
    int k = 0;
    @(negedge clk);
    while (!cmd_ready && k < 100) begin
      @(negedge clk);
      k++;
    end
    if (!cmd_ready) chk("ready_timeout", 32'(cmd_ready), 1);
    cmd_we = we; cmd_addr = addr; cmd_wdata = wd; cmd_be = be; cmd_valid = 1;
    if (!we) sb.push_back(exp);
    @(posedge clk);
    #1 if (!hold) cmd_valid = 0;
  endtask

  task automatic trace(input int n);
    for (int k = 1; k <= n; k++) begin
      @(negedge clk);
      tr_we[k] = we_n; tr_oe[k] = oe_n; tr_rdy[k] = cmd_ready; tr_rv[k] = rsp_valid;
    end
  endtask

  task automatic chk_read_timing();
    for (int k = 1; k <= 4; k++) chk($sformatf("rd_oe_n_c%0d", k), 32'(tr_oe[k]), 32'(k > 2));
    chk("rd_rv_c2", 32'(tr_rv[2]), 0);
    chk("rd_rv_c3", 32'(tr_rv[3]), 1);
    chk("rd_rdy_c3", 32'(tr_rdy[3]), 0);
    chk("rd_rdy_c4", 32'(tr_rdy[4]), 1);
  endtask

  initial begin
    repeat (2) @(negedge clk);
    chk("rst_ready", 32'(cmd_ready), 1);
    chk("rst_rv", 32'(rsp_valid), 0);
    chk("rst_rdata", 32'(rsp_rdata), 0);
    chk("rst_a", 32'(sram_a), 0);
    chk("rst_dq_o", 32'(dq_o), 0);
    chk("rst_strobes", {27'd0, dq_oe, ce_n, oe_n, we_n, 1'b0}, {27'd0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0});
    chk("rst_be_n", 32'(be_n), 3);
    rst = 0;
    issue(1, 18'h12, 16'hA55A, 2'b11, 0, 0);
    trace(6);
    for (int k = 1; k <= 5; k++) chk($sformatf("wr_we_n_c%0d", k), 32'(tr_we[k]), 32'(!(k == 2 || k == 3)));
    chk("wr_rdy_c4", 32'(tr_rdy[4]), 0);
    chk("wr_rdy_c5", 32'(tr_rdy[5]), 1);
    chk("wr_mem", 32'(mem[8'h12]), 32'hA55A);
    issue(0, 18'h12, 0, 0, 16'hA55A, 0);
    trace(5);
    chk_read_timing();
    issue(1, 18'h12, 16'h1234, 2'b01, 0, 0);
    trace(6);
    chk("be01_mem", 32'(mem[8'h12]), 32'hA534);
    issue(0, 18'h12, 0, 0, 16'hA534, 0);
    trace(5);
    issue(1, 18'h12, 16'hFFFF, 2'b00, 0, 0);
    trace(6);
    for (int k = 1; k <= 5; k++) chk($sformatf("be00_we_n_c%0d", k), 32'(tr_we[k]), 1);
    issue(0, 18'h12, 0, 0, 16'hA534, 0);
    trace(5);
    chk_read_timing();
    @(negedge clk);
    c1_valid = 1;
    @(posedge clk);
    #1 c1_valid = 0;
    for (int k = 1; k <= 6; k++) begin
      @(negedge clk);
      chk($sformatf("w3_rv_c%0d", k), 32'(c1_rv), 32'(k == 5));
      if (k == 4) chk("w3_rdy_c4", 32'(c1_ready), 0);
      if (k == 5) chk("w3_rdy_c5", 32'(c1_ready), 1);
      if (k == 5) chk("w3_rdata", 32'(c1_rdata), 32'h5A5A);
    end
    issue(0, 18'h12, 0, 0, 16'hA534, 1);
    issue(1, 18'h20, 16'hBEEF, 2'b11, 0, 1);
    issue(0, 18'h20, 0, 0, 16'hBEEF, 0);
    trace(6);
    chk("b2b_mem", 32'(mem[8'h20]), 32'hBEEF);
    issue(1, 18'h30, 16'h1111, 2'b11, 0, 0);
    @(negedge clk);
    @(negedge clk);
    chk("abort_pulse_low", 32'(we_n), 0);
    #1 rst = 1;
    #1;
    chk("abort_strobes", {28'd0, we_n, ce_n, oe_n, dq_oe}, {28'd0, 1'b1, 1'b1, 1'b1, 1'b0});
    @(negedge clk);
    rst = 0;
    issue(0, 18'h12, 0, 0, 16'hA534, 0);
    trace(5);
    chk_read_timing();
    repeat (3) @(negedge clk);
    chk("sb_empty", 32'(sb.size()), 0);
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end
endmodule
